// File: rtl/memory_access_stage_pkg.sv
// Shared encodings for the M stage: result-source codes, bus FSM state codes
// and the word-alignment helper used to form bus addresses.
package memory_access_stage_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_REQ  = 2'd1,
      MS_WAIT = 2'd2,
      MS_DONE = 2'd3
   } ms_state_t;

   function automatic logic [31:0] word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-bus interface between the M stage (master) and memory (slave).
interface memory_access_stage_if;

   // Request transfers on a rising edge where mem_req_valid & mem_req_ready;
   // valid and the request fields stay stable until then. mem_resp_valid is a
   // one-cycle strobe carrying load data, at the earliest one cycle after accept.
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   modport master (
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

endinterface

// File: rtl/memory_access_stage_mem_bus_fsm.sv
// Bus access sequencer: IDLE/REQ/WAIT/DONE FSM, load data capture and StallM.
// Defining MEM_TIMEOUT_EN adds an abort counter and the sticky mem_err flag.
module mem_bus_fsm
   import memory_access_stage_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        acc,
   input  logic        is_store,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [31:0] resp_rdata,
   output logic        req_valid,
   output logic        stall,
   output logic [31:0] rdata_q,
   output logic        mem_err,
   output ms_state_t   state
);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             timeout;

   // >= rather than == so a load accepted on the last allowed cycle still aborts
   assign timeout = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam logic [31:0] unused_cfg = ERR_RDATA ^ 32'(TIMEOUT_CYCLES);

   assign mem_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= MS_IDLE;
         rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt     <= '0;
         mem_err <= 1'b0;
`endif
      end else begin
`ifdef MEM_TIMEOUT_EN
         cnt <= (state == MS_REQ || state == MS_WAIT) ? cnt + 1'b1 : '0;
`endif
         case (state)
            MS_IDLE: if (acc) state <= MS_REQ;
            MS_REQ: begin
               if (req_ready) state <= is_store ? MS_DONE : MS_WAIT;
`ifdef MEM_TIMEOUT_EN
               else if (timeout) begin
                  state   <= MS_DONE;
                  rdata_q <= ERR_RDATA;
                  mem_err <= 1'b1;
               end
`endif
            end
            MS_WAIT: begin
               if (resp_valid) begin
                  rdata_q <= resp_rdata;
                  state   <= MS_DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (timeout) begin
                  state   <= MS_DONE;
                  rdata_q <= ERR_RDATA;
                  mem_err <= 1'b1;
               end
`endif
            end
            MS_DONE: state <= MS_IDLE;
            default: state <= MS_IDLE;
         endcase
      end
   end

   assign req_valid = (state == MS_REQ);

   // resetn gates the stall so the front end is released the moment reset asserts
   assign stall = resetn & acc & (state != MS_DONE);

endmodule

// File: rtl/memory_access_stage.sv
// RV32 pipeline M stage: word loads/stores over the data bus, M->W register
// and ResultW mux. Optional bus timeout abort: define MEM_TIMEOUT_EN.
module memory_access_stage
   import memory_access_stage_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  RegWriteM,
   input  logic [1:0]            ResultSrcM,
   input  logic                  MemWriteM,
   input  logic [31:0]           ALUResultM,
   input  logic [31:0]           WriteDataM,
   input  logic [4:0]            RdM,
   input  logic [31:0]           PCPlus4M,
   output logic                  StallM,
   memory_access_stage_if.master bus,
   output logic                  mem_err,
   output logic                  RegWriteW,
   output logic [1:0]            ResultSrcW,
   output logic [31:0]           ALUResultW,
   output logic [31:0]           ReadDataW,
   output logic [4:0]            RdW,
   output logic [31:0]           PCPlus4W,
   output logic [31:0]           ResultW,
   output ms_state_t             dbg_state
);

   logic        acc;
   logic        is_load;
   logic [31:0] rdata_q;

   // A store with ResultSrcM==01 is still a store; it never returns load data
   assign is_load = (ResultSrcM == RES_MEM) & ~MemWriteM;
   assign acc     = MemWriteM | (ResultSrcM == RES_MEM);

   assign bus.mem_req_we    = MemWriteM;
   assign bus.mem_req_addr  = word_addr(ALUResultM);
   assign bus.mem_req_wdata = WriteDataM;

   mem_bus_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .ERR_RDATA      (ERR_RDATA)
   ) u_fsm (
      .clk        (clk),
      .resetn     (resetn),
      .acc        (acc),
      .is_store   (MemWriteM),
      .req_ready  (bus.mem_req_ready),
      .resp_valid (bus.mem_resp_valid),
      .resp_rdata (bus.mem_resp_rdata),
      .req_valid  (bus.mem_req_valid),
      .stall      (StallM),
      .rdata_q    (rdata_q),
      .mem_err    (mem_err),
      .state      (dbg_state)
   );

   // Held while stalled so W-stage forwarding stays valid for the frozen E instruction
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= RES_ALU;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         RdW        <= '0;
         PCPlus4W   <= '0;
      end else if (!StallM) begin
         RegWriteW  <= RegWriteM;
         ResultSrcW <= ResultSrcM;
         ALUResultW <= ALUResultM;
         ReadDataW  <= is_load ? rdata_q : '0;
         RdW        <= RdM;
         PCPlus4W   <= PCPlus4M;
      end
   end

   always_comb begin
      ResultW = '0;
      case (ResultSrcW)
         RES_ALU: ResultW = ALUResultW;
         RES_MEM: ResultW = ReadDataW;
         RES_PC4: ResultW = PCPlus4W;
         default: ResultW = '0;
      endcase
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed vector table, reset-in-WAIT sequence,
// random program against a reference model; timeout sequence with MEM_TIMEOUT_EN.
module tb_memory_access_stage;
   import memory_access_stage_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        reg_write_m, mem_write_m;
   logic [1:0]  result_src_m;
   logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
   logic [4:0]  rd_m;
   logic        stall_m, mem_err, reg_write_w;
   logic [1:0]  result_src_w;
   logic [31:0] alu_result_w, read_data_w, pc_plus4_w, result_w;
   logic [4:0]  rd_w;
   ms_state_t   dbg_state;

   memory_access_stage_if bus ();

   memory_access_stage #(
      .TIMEOUT_CYCLES (4),
      .ERR_RDATA      (32'hDEADBEEF)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .RegWriteM  (reg_write_m),
      .ResultSrcM (result_src_m),
      .MemWriteM  (mem_write_m),
      .ALUResultM (alu_result_m),
      .WriteDataM (write_data_m),
      .RdM        (rd_m),
      .PCPlus4M   (pc_plus4_m),
      .StallM     (stall_m),
      .bus        (bus),
      .mem_err    (mem_err),
      .RegWriteW  (reg_write_w),
      .ResultSrcW (result_src_w),
      .ALUResultW (alu_result_w),
      .ReadDataW  (read_data_w),
      .RdW        (rd_w),
      .PCPlus4W   (pc_plus4_w),
      .ResultW    (result_w),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] bus_mem[int];
   logic [31:0] ref_mem[int];
   logic [31:0] last_res = '0;
   logic [4:0]  last_rd = '0;

   int          cur_d = 0, cur_r = 1, accept_cnt = 0;
   logic        exp_we = 1'b0;
   logic [31:0] exp_addr = '0, exp_wdata = '0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int idx);
      return 32'h5EED0000 + 32'(idx);
   endfunction

   function automatic logic [31:0] bus_rd(input int idx);
      return bus_mem.exists(idx) ? bus_mem[idx] : init_word(idx);
   endfunction

   function automatic logic [31:0] ref_rd(input int idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
   endfunction

   // ---------------- bus slave: delayed ready, delayed response, junk strobes ----------------
   initial begin
      int          wait_cnt;
      int          resp_cnt;
      logic [31:0] resp_addr;
      wait_cnt = 0;
      resp_cnt = 0;
      resp_addr = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            wait_cnt = 0;
            resp_cnt = 0;
            continue;
         end
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_rdata = $urandom;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_rdata = bus_rd(int'(resp_addr[31:2]));
            end
         end else if ($urandom_range(0, 3) == 0) begin
            bus.mem_resp_valid = 1'b1;
         end
         if (bus.mem_req_valid) begin
            bus.mem_req_ready = (wait_cnt >= cur_d);
            if (bus.mem_req_ready) begin
               accept_cnt++;
               wait_cnt = 0;
               check32("req_addr", bus.mem_req_addr, exp_addr);
               check32("req_we", 32'(bus.mem_req_we), 32'(exp_we));
               if (bus.mem_req_we) begin
                  check32("req_wdata", bus.mem_req_wdata, exp_wdata);
                  bus_mem[int'(bus.mem_req_addr[31:2])] = bus.mem_req_wdata;
               end else begin
                  resp_cnt  = cur_r;
                  resp_addr = bus.mem_req_addr;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            bus.mem_req_ready = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // ---------------- driver: present one E/M instruction, run it to retirement ----------------
   task automatic run_instr(input logic rw, input logic [1:0] src, input logic we,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [31:0] pc4, input logic [4:0] rd,
                            input int d, input int r, input logic [31:0] exp_res,
                            input int exp_stall, input int exp_acc);
      int   stalls;
      bit   done;
      logic is_load;
      reg_write_m  = rw;
      result_src_m = src;
      mem_write_m  = we;
      alu_result_m = alu;
      write_data_m = wd;
      pc_plus4_m   = pc4;
      rd_m         = rd;
      cur_d        = d;
      cur_r        = r;
      exp_addr     = {alu[31:2], 2'b00};
      exp_we       = we;
      exp_wdata    = wd;
      accept_cnt   = 0;
      is_load      = (src == RES_MEM) && !we;
      exp_q.push_back(exp_res);
      if (we) ref_mem[int'(alu[31:2])] = wd;
      stalls = 0;
      done   = 1'b0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge clk);
         if (stall_m) begin
            stalls++;
            check32("hold_result_w", result_w, last_res);
            check32("hold_rd_w", 32'(rd_w), 32'(last_rd));
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL stall_bound: StallM still 1 after 300 cycles, expected release");
      end
      @(posedge clk);
      #1;
      check32("stall_cycles", 32'(stalls), 32'(exp_stall));
      check32("bus_accepts", 32'(accept_cnt), 32'(exp_acc));
      check32("result_w", result_w, exp_q.pop_front());
      check32("read_data_w", read_data_w, is_load ? exp_res : 32'h0);
      check32("reg_write_w", 32'(reg_write_w), 32'(rw));
      check32("result_src_w", 32'(result_src_w), 32'(src));
      check32("rd_w", 32'(rd_w), 32'(rd));
      check32("alu_result_w", alu_result_w, alu);
      check32("pc_plus4_w", pc_plus4_w, pc4);
      last_res = exp_res;
      last_rd  = rd;
   endtask

   typedef struct {
      logic        rw;
      logic [1:0]  src;
      logic        we;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc4;
      logic [4:0]  rd;
      int          d;
      int          r;
      logic [31:0] exp_res;
      int          exp_stall;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic        rw, we, is_load;
      logic [1:0]  src;
      logic [31:0] alu, wd, pc4, rdv, res;
      logic [4:0]  rd;
      int          d, r, stl, acc;

      //          rw    src      we    alu           wd            pc4           rd     d  r  exp_res       stall
      vecs[0] = '{1'b1, RES_ALU, 1'b0, 32'h0000002A, 32'h00000000, 32'h00000104, 5'd5,  0, 1, 32'h0000002A, 0};
      vecs[1] = '{1'b0, RES_ALU, 1'b1, 32'h00000103, 32'h00001234, 32'h00000108, 5'd0,  0, 1, 32'h00000103, 2};
      vecs[2] = '{1'b1, RES_MEM, 1'b0, 32'h00000040, 32'h00000000, 32'h0000010C, 5'd7,  3, 1, 32'hCAFEF00D, 6};
      vecs[3] = '{1'b1, RES_MEM, 1'b0, 32'h00000100, 32'h00000000, 32'h00000110, 5'd8,  0, 1, 32'h00001234, 3};
      vecs[4] = '{1'b1, RES_PC4, 1'b0, 32'h00000055, 32'h00000000, 32'h00000200, 5'd1,  0, 1, 32'h00000200, 0};
      vecs[5] = '{1'b1, 2'b11,   1'b0, 32'h00000077, 32'h00000000, 32'h00000204, 5'd2,  0, 1, 32'h00000000, 0};
      vecs[6] = '{1'b1, RES_MEM, 1'b1, 32'h00000044, 32'h0000A5A5, 32'h00000208, 5'd9,  1, 1, 32'h00000000, 3};
      vecs[7] = '{1'b1, RES_MEM, 1'b0, 32'h00000044, 32'h00000000, 32'h0000020C, 5'd10, 0, 2, 32'h0000A5A5, 4};
      vecs[8] = '{1'b1, RES_MEM, 1'b0, 32'h00000047, 32'h00000000, 32'h00000210, 5'd11, 2, 3, 32'h0000A5A5, 7};

      bus_mem[32'h10] = 32'hCAFEF00D;
      ref_mem[32'h10] = 32'hCAFEF00D;

      reg_write_m = 1'b0; result_src_m = RES_ALU; mem_write_m = 1'b0;
      alu_result_m = '0; write_data_m = '0; pc_plus4_m = '0; rd_m = '0;

      repeat (3) @(posedge clk);
      #1;
      check32("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
      check32("rst_stall", 32'(stall_m), 32'h0);
      check32("rst_result_w", result_w, 32'h0);
      check32("rst_reg_write_w", 32'(reg_write_w), 32'h0);
      check32("rst_mem_err", 32'(mem_err), 32'h0);
      check32("rst_state", 32'(dbg_state), 32'(MS_IDLE));
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // ---------------- directed vector table ----------------
      foreach (vecs[i]) begin
         acc = (vecs[i].we || vecs[i].src == RES_MEM) ? 1 : 0;
         run_instr(vecs[i].rw, vecs[i].src, vecs[i].we, vecs[i].alu, vecs[i].wd,
                   vecs[i].pc4, vecs[i].rd, vecs[i].d, vecs[i].r, vecs[i].exp_res,
                   vecs[i].exp_stall, acc);
      end

      // ---------------- reset while a load waits for its response ----------------
      reg_write_m = 1'b1; result_src_m = RES_MEM; mem_write_m = 1'b0;
      alu_result_m = 32'h80; write_data_m = '0; pc_plus4_m = 32'h300; rd_m = 5'd3;
      cur_d = 0; cur_r = 6; exp_addr = 32'h80; exp_we = 1'b0; exp_wdata = '0;
      @(posedge clk);
      @(posedge clk);
      #3;
      check32("pre_reset_state", 32'(dbg_state), 32'(MS_WAIT));
      resetn = 1'b0;
      #1;
      check32("mid_rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
      check32("mid_rst_stall", 32'(stall_m), 32'h0);
      check32("mid_rst_result_w", result_w, 32'h0);
      check32("mid_rst_read_data_w", read_data_w, 32'h0);
      check32("mid_rst_reg_write_w", 32'(reg_write_w), 32'h0);
      check32("mid_rst_rd_w", 32'(rd_w), 32'h0);
      check32("mid_rst_alu_result_w", alu_result_w, 32'h0);
      check32("mid_rst_pc_plus4_w", pc_plus4_w, 32'h0);
      reg_write_m = 1'b0; result_src_m = RES_ALU; alu_result_m = '0; pc_plus4_m = '0; rd_m = '0;
      @(posedge clk);
      #2;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check32("post_rst_state", 32'(dbg_state), 32'(MS_IDLE));
      check32("post_rst_stall", 32'(stall_m), 32'h0);
      last_res = '0;
      last_rd  = '0;

      // ---------------- random program against the reference model ----------------
      for (int i = 0; i < 150; i++) begin
         rw  = 1'($urandom_range(0, 1));
         src = 2'($urandom_range(0, 3));
         we  = ($urandom_range(0, 3) == 0);
         alu = 32'($urandom_range(0, 255));
         wd  = $urandom;
         pc4 = $urandom;
         rd  = 5'($urandom_range(0, 31));
         d   = $urandom_range(0, 3);
         r   = $urandom_range(1, 3);
         is_load = (src == RES_MEM) && !we;
         rdv = is_load ? ref_rd(int'(alu[31:2])) : 32'h0;
         case (src)
            RES_ALU: res = alu;
            RES_MEM: res = rdv;
            RES_PC4: res = pc4;
            default: res = 32'h0;
         endcase
         stl = we ? d + 2 : (is_load ? d + 2 + r : 0);
         acc = (we || src == RES_MEM) ? 1 : 0;
         run_instr(rw, src, we, alu, wd, pc4, rd, d, r, res, stl, acc);
      end

`ifdef MEM_TIMEOUT_EN
      // ---------------- bus never ready: abort after 4 cycles ----------------
      run_instr(1'b1, RES_MEM, 1'b0, 32'h0C0, 32'h0, 32'h11, 5'd12, 1000, 1, 32'hDEADBEEF, 5, 0);
      check32("timeout_mem_err", 32'(mem_err), 32'h1);
      run_instr(1'b1, RES_ALU, 1'b0, 32'h99, 32'h0, 32'h15, 5'd13, 0, 1, 32'h99, 0, 0);
      check32("sticky_mem_err", 32'(mem_err), 32'h1);
      resetn = 1'b0;
      #1;
      check32("rst_clears_mem_err", 32'(mem_err), 32'h0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
`else
      check32("mem_err_tied_low", 32'(mem_err), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
